io_bus_parser_bank: RTL
=======================

IO_BUS_PARSER_BANK -- requirements
Module: io_bus_parser_bank

Interface
REQ-001 SHALL have parameter P_BASE_ADDR, default 16'hFF00, address of register 0; register i sits at P_BASE_ADDR+i.
REQ-002 SHALL have parameter P_NUM_REGS, default 4, register count, legal range 1..16.
REQ-003 SHALL have parameter P_RST_VALS, default all 8'h00, packed 8*P_NUM_REGS reset values, register i at bits [8i+7:8i].
REQ-004 SHALL have parameter P_MODE_VEC, default all 2'b00, packed 2 bits per register: 00 read/write, 01 write-only, 10 read-only.
REQ-005 SHALL have parameter P_WMASK, default all 8'hFF, packed per-register bus-write bit mask; 1 = bit bus-writable.
REQ-006 SHALL have parameter P_ROC_VEC, default all 0, one bit per register: 1 = reset-on-read.
REQ-007 SHALL have parameter P_FORWARD_DATA, default 0: 1 = bus read returns I_DATA_WR slice when that register's I_REG_WR_EN is high.
REQ-008 SHALL have port I_CLK, input, 1, sole clock; all state on rising edge.
REQ-009 SHALL have port I_SYNC_RESET_L, input, 1, reset, synchronous, active-low.
REQ-010 SHALL have port IO_DATA_BUS, inout, 8, tristate CPU data bus.
REQ-011 SHALL have port I_ADDR_BUS, input, 16, CPU address.
REQ-012 SHALL have ports I_WE_BUS_L and I_RE_BUS_L, input, 1 each, active-low bus write/read.
REQ-013 SHALL have port I_DATA_WR, input, 8*P_NUM_REGS, external-module write data.
REQ-014 SHALL have port I_REG_WR_EN, input, P_NUM_REGS, per-register external write enable.
REQ-015 SHALL have port O_DATA_READ, output, 8*P_NUM_REGS, current register contents.
REQ-016 SHALL have port O_DBUS_WRITE, output, P_NUM_REGS, one-cycle pulse per register after a bus write.
REQ-017 SHALL have port O_WAIT, output, P_NUM_REGS, combinational: high while I_WE_BUS_L low and address hits register i.

Function
REQ-018 Hit: register i hit when I_ADDR_BUS == P_BASE_ADDR+i (16-bit compare, no wrap past 16'hFFFF); addresses outside range hit nothing.
REQ-019 Bus drive: IO_DATA_BUS driven only when I_RE_BUS_L low, a register hit, and its mode != 01; else 8'hZZ.
REQ-020 Bus write (I_WE_BUS_L low, hit, mode != 10): reg <= (bus & WMASK) | (reg & ~WMASK); O_DBUS_WRITE[i] = 1 next cycle.
REQ-021 Priority per register: bus write > external write > hold; external write ignores WMASK and mode.
REQ-022 External writes to registers not hit by the bus SHALL proceed in the same cycle as a bus write to another register.
REQ-023 Reset-on-read: clear fires once, on the cycle after read ends (I_RE_BUS_L rises or address leaves the register), not every cycle of the read; bus sees pre-clear value throughout.
REQ-024 Read tracking: 2-state FSM IDLE/READING with latched register index; IDLE->READING on hit read of ROC register; READING->IDLE issuing clear when read ends.
REQ-025 Clear vs. write same cycle: bus or external write wins over pending clear; clear discarded.
REQ-026 Both WE_L and RE_L low: treated as write; no read tracking started.

Reset
REQ-027 On I_SYNC_RESET_L low at a clock edge: every register <= its P_RST_VALS slice, O_DBUS_WRITE <= 0, FSM <= IDLE; reset overrides all other actions.

Configuration
REQ-028 With IO_BUS_PARSER_BANK_SET_EN defined: port I_SET_BITS, input, 8*P_NUM_REGS, ORs bits into registers each cycle (sticky flags); set beats same-cycle clear and WMASK-cleared bus bits.
REQ-029 Without IO_BUS_PARSER_BANK_SET_EN: no I_SET_BITS port, no set logic.

Structure
REQ-030 Mode encodings (RW, WO, RO) and max register count SHALL live in shared package io_bus_pkg.
REQ-031 Per-register storage SHALL be sub-module io_bank_cell, generated P_NUM_REGS times; decode, bus mux, and read FSM in the top.

Verification
REQ-032 Bus write 8'hA5 to base+1, WMASK 8'h0F, reg=8'h30 -> reg 8'h35, O_DBUS_WRITE[1] one cycle.
REQ-033 Same-cycle bus write 8'h11 and external write 8'h22 to reg 0 -> reg 8'h11; external 8'h33 to reg 2 that cycle -> reg 2 = 8'h33.
REQ-034 ROC reg = 8'h5A, read held 3 cycles -> bus shows 8'h5A all 3 cycles, reg 8'h00 one cycle after read ends.
REQ-035 Read of write-only reg or address base+P_NUM_REGS -> IO_DATA_BUS stays Z.
REQ-036 Reset low mid-read of ROC reg with P_RST_VALS 8'h80 -> reg 8'h80, FSM IDLE, no later clear.
REQ-037 SET_EN build: I_SET_BITS 8'h04 during clear cycle on reg=8'h01 -> reg 8'h04.

Source files
------------

// File: rtl/io_bus_pkg.sv
// rtl/io_bus_pkg.sv - shared mode encodings, limits and read-tracker states for the register bank
package io_bus_pkg;

  typedef enum logic [1:0] {
    MODE_RW = 2'b00,
    MODE_WO = 2'b01,
    MODE_RO = 2'b10
  } reg_mode_e;

  localparam int MAX_REGS = 16;

  typedef enum logic {
    RD_IDLE    = 1'b0,
    RD_READING = 1'b1
  } rd_state_e;

  function automatic logic mode_readable(input logic [1:0] mode);
    return mode != MODE_WO;
  endfunction

  function automatic logic mode_writable(input logic [1:0] mode);
    return mode != MODE_RO;
  endfunction

endpackage

// File: rtl/io_bank_cell.sv
// rtl/io_bank_cell.sv - one 8-bit register with bus/external write, clear and write pulse
// Optional sticky set inputs: IO_BUS_PARSER_BANK_SET_EN
module io_bank_cell #(
  parameter logic [7:0] P_RST_VAL = 8'h00,
  parameter logic [7:0] P_WMASK   = 8'hFF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       bus_wr_i,
  input  logic [7:0] bus_data_i,
  input  logic       ext_wr_i,
  input  logic [7:0] ext_data_i,
  input  logic       clr_i,
`ifdef IO_BUS_PARSER_BANK_SET_EN
  input  logic [7:0] set_bits_i,
`endif
  output logic [7:0] data_o,
  output logic       wr_pulse_o
);

  logic [7:0] data_d, data_q;
  logic       pulse_q;

  // Any write discards a same-cycle clear; set bits are applied last so they always stick.
  always_comb begin
    data_d = data_q;
    if (bus_wr_i) begin
      data_d = (bus_data_i & P_WMASK) | (data_q & ~P_WMASK);
    end else if (ext_wr_i) begin
      data_d = ext_data_i;
    end else if (clr_i) begin
      data_d = 8'h00;
    end
`ifdef IO_BUS_PARSER_BANK_SET_EN
    data_d = data_d | set_bits_i;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q  <= P_RST_VAL;
      pulse_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      pulse_q <= bus_wr_i;
    end
  end

  assign data_o     = data_q;
  assign wr_pulse_o = pulse_q;

endmodule

// File: rtl/io_bus_parser_bank.sv
// rtl/io_bus_parser_bank.sv - CPU bus register bank: decode, tristate read mux, reset-on-read tracker
// Optional sticky set inputs: IO_BUS_PARSER_BANK_SET_EN
module io_bus_parser_bank
  import io_bus_pkg::*;
#(
  parameter logic [15:0]             P_BASE_ADDR    = 16'hFF00,
  parameter int                      P_NUM_REGS     = 4,
  parameter logic [8*P_NUM_REGS-1:0] P_RST_VALS     = '0,
  parameter logic [2*P_NUM_REGS-1:0] P_MODE_VEC     = '0,
  parameter logic [8*P_NUM_REGS-1:0] P_WMASK        = '1,
  parameter logic [P_NUM_REGS-1:0]   P_ROC_VEC      = '0,
  parameter bit                      P_FORWARD_DATA = 1'b0
) (
  input  logic                      I_CLK,
  input  logic                      I_SYNC_RESET_L,
  inout  wire  [7:0]                IO_DATA_BUS,
  input  logic [15:0]               I_ADDR_BUS,
  input  logic                      I_WE_BUS_L,
  input  logic                      I_RE_BUS_L,
  input  logic [8*P_NUM_REGS-1:0]   I_DATA_WR,
  input  logic [P_NUM_REGS-1:0]     I_REG_WR_EN,
`ifdef IO_BUS_PARSER_BANK_SET_EN
  input  logic [8*P_NUM_REGS-1:0]   I_SET_BITS,
`endif
  output logic [8*P_NUM_REGS-1:0]   O_DATA_READ,
  output logic [P_NUM_REGS-1:0]     O_DBUS_WRITE,
  output logic [P_NUM_REGS-1:0]     O_WAIT
);

  logic                    wr_active, rd_active;
  logic [P_NUM_REGS-1:0]   hit, bus_wr, rd_hit, start_sel, clr;
  logic [8*P_NUM_REGS-1:0] cell_data;
  logic                    rd_drive;
  logic [7:0]              rd_data;
  rd_state_e               state_d, state_q;
  logic [P_NUM_REGS-1:0]   sel_d, sel_q;

  // A cycle with both strobes low is a write; it never counts as a read.
  assign wr_active = !I_WE_BUS_L;
  assign rd_active = !I_RE_BUS_L && I_WE_BUS_L;

  for (genvar i = 0; i < P_NUM_REGS; i++) begin : g_reg
    // 17-bit compare so registers past 16'hFFFF are unreachable instead of aliasing low addresses.
    assign hit[i]    = ({1'b0, I_ADDR_BUS} == ({1'b0, P_BASE_ADDR} + 17'(i)));
    assign bus_wr[i] = wr_active && hit[i] && mode_writable(P_MODE_VEC[2*i +: 2]);
    assign rd_hit[i] = rd_active && hit[i] && mode_readable(P_MODE_VEC[2*i +: 2]);

    io_bank_cell #(
      .P_RST_VAL (P_RST_VALS[8*i +: 8]),
      .P_WMASK   (P_WMASK[8*i +: 8])
    ) u_cell (
      .clk_i      (I_CLK),
      .rst_ni     (I_SYNC_RESET_L),
      .bus_wr_i   (bus_wr[i]),
      .bus_data_i (IO_DATA_BUS),
      .ext_wr_i   (I_REG_WR_EN[i]),
      .ext_data_i (I_DATA_WR[8*i +: 8]),
      .clr_i      (clr[i]),
`ifdef IO_BUS_PARSER_BANK_SET_EN
      .set_bits_i (I_SET_BITS[8*i +: 8]),
`endif
      .data_o     (cell_data[8*i +: 8]),
      .wr_pulse_o (O_DBUS_WRITE[i])
    );
  end

  assign O_DATA_READ = cell_data;
  assign O_WAIT      = hit & {P_NUM_REGS{wr_active}};

  always_comb begin
    rd_drive = 1'b0;
    rd_data  = 8'h00;
    for (int i = 0; i < P_NUM_REGS; i++) begin
      if (rd_hit[i]) begin
        rd_drive = 1'b1;
        rd_data  = (P_FORWARD_DATA && I_REG_WR_EN[i]) ? I_DATA_WR[8*i +: 8]
                                                       : cell_data[8*i +: 8];
      end
    end
  end

  assign IO_DATA_BUS = rd_drive ? rd_data : 8'hzz;

  // The tracked register is held one-hot; the clear is issued in the first cycle it is no longer read.
  assign start_sel = rd_hit & P_ROC_VEC;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    clr     = '0;
    case (state_q)
      RD_IDLE: begin
        if (|start_sel) begin
          state_d = RD_READING;
          sel_d   = start_sel;
        end
      end
      RD_READING: begin
        if ((rd_hit & sel_q) == '0) begin
          clr = sel_q;
          if (|start_sel) begin
            sel_d = start_sel;
          end else begin
            state_d = RD_IDLE;
            sel_d   = '0;
          end
        end
      end
      default: begin
        state_d = RD_IDLE;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (!I_SYNC_RESET_L) begin
      state_q <= RD_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

endmodule
